// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the periodic serial sequence generator.
package seq_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  // x^10 + x^7 + 1, maximal length for a 10-bit Fibonacci LFSR
  localparam logic [9:0] LFSR_TAPS_W10 = 10'h240;

endpackage

// File: rtl/seq_gen_if.sv
// Load handshake and serial output bundle for seq_gen_param.
interface seq_gen_if #(
  parameter int WIDTH = 10
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_mode;
  logic             en;
  logic             q;
  logic             q_valid;
  logic             frame_start;

  modport master (
    output load_valid, load_data, load_mode, en,
    input  load_ready, q, q_valid, frame_start
  );

  modport slave (
    input  load_valid, load_data, load_mode, en,
    output load_ready, q, q_valid, frame_start
  );
endinterface

// File: rtl/seq_gen_next.sv
// Next-state and serial output bit of the pattern shift register.
// Build option SEQ_GEN_LFSR_EN adds the LFSR feedback path; without it
// the register only rotates and no XOR feedback is built.
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(LFSR_TAPS_W10),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] sr,
  input  logic             mode,
  output logic [WIDTH-1:0] sr_next,
  output logic             out_bit
);

  logic [WIDTH-1:0] sr_rot;

  assign out_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign sr_rot  = MSB_FIRST ? {sr[WIDTH-2:0], sr[WIDTH-1]} : {sr[0], sr[WIDTH-1:1]};

`ifdef SEQ_GEN_LFSR_EN
  logic fb;

  assign fb = ^(sr & LFSR_TAPS);

  // choose rotate or LFSR step; shift direction follows the emit order
  always_comb begin
    sr_next = sr_rot;
    if (mode == MODE_LFSR) begin
      sr_next = MSB_FIRST ? {sr[WIDTH-2:0], fb} : {fb, sr[WIDTH-1:1]};
    end
  end
`else
  localparam logic [WIDTH-1:0] unused_taps = LFSR_TAPS;
  logic unused_mode;

  assign unused_mode = mode;
  assign sr_next     = sr_rot;
`endif

endmodule

// File: rtl/seq_gen_param.sv
// Periodic serial sequence generator: loads a WIDTH-bit pattern over a
// valid/ready handshake and emits it one bit per enabled cycle, forever.
// Build option SEQ_GEN_LFSR_EN enables the LFSR (PRBS) mode; otherwise
// load_mode is ignored and every pattern rotates.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no pattern loaded, no output, always ready to accept
//  ST_RUN  | emitting; a new pattern is taken only with the last bit
module seq_gen_param
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(LFSR_TAPS_W10),
  parameter bit               MSB_FIRST = 1'b1
) (
  input logic     clk,
  input logic     reset,
  seq_gen_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic             q_r;
  logic             q_valid_r;
  logic             frame_start_r;

  logic [WIDTH-1:0] sr_next;
  logic             out_bit;
  logic             ready;
  logic             accept;
  logic             load_mode_eff;
  logic [WIDTH-1:0] seed;

  // ready while idle, or in the cycle the last bit of a frame is emitted
  assign ready  = (state == ST_IDLE) || ((state == ST_RUN) && bus.en && (cnt == CNT_LAST));
  assign accept = bus.load_valid && ready;

`ifdef SEQ_GEN_LFSR_EN
  // an all-zero LFSR would lock up, so a zero seed becomes 1
  assign load_mode_eff = bus.load_mode;
  assign seed = ((bus.load_mode == MODE_LFSR) && (bus.load_data == '0))
                ? WIDTH'(1) : bus.load_data;
`else
  logic unused_load_mode;

  assign unused_load_mode = bus.load_mode;
  assign load_mode_eff    = MODE_ROTATE;
  assign seed             = bus.load_data;
`endif

  seq_gen_next #(
    .WIDTH     (WIDTH),
    .LFSR_TAPS (LFSR_TAPS),
    .MSB_FIRST (MSB_FIRST)
  ) u_next (
    .sr      (sr),
    .mode    (mode),
    .sr_next (sr_next),
    .out_bit (out_bit)
  );

  // control FSM with registered serial outputs; a reload with the last bit
  // keeps the stream gapless
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      sr            <= '0;
      cnt           <= '0;
      mode          <= MODE_ROTATE;
      q_r           <= 1'b0;
      q_valid_r     <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      q_valid_r     <= 1'b0;
      frame_start_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr    <= seed;
            mode  <= load_mode_eff;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            q_r           <= out_bit;
            q_valid_r     <= 1'b1;
            frame_start_r <= (cnt == '0);
            if (accept) begin
              sr   <= seed;
              mode <= load_mode_eff;
              cnt  <= '0;
            end else begin
              sr  <= sr_next;
              cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready  = ready;
  assign bus.q           = q_r;
  assign bus.q_valid     = q_valid_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_seq_gen_param.sv
// Self-checking bench for seq_gen_param (WIDTH=10, MSB_FIRST=1).
// Expected streams come from the output-bit recurrence of the pattern:
// rotate repeats the pattern, LFSR obeys o[k] = XOR of taps over o[k-1-i].
module tb_seq_gen_param;

  localparam int               W    = 10;
  localparam logic [W-1:0]     TAPS = 10'h240;
  localparam int               NS   = 1200;
  localparam logic [W-1:0]     SPEC_PAT = 10'b1011001110;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(W)) bus ();

  seq_gen_param #(
    .WIDTH     (W),
    .LFSR_TAPS (TAPS),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_s [0:NS-1];
  logic got_s [0:NS-1];

  // expected emitted stream for a pattern loaded with the given mode
  function automatic void build_stream(input logic [W-1:0] data, input logic mode);
    logic [W-1:0] s;
    logic         fb;
    logic         lfsr;
`ifdef SEQ_GEN_LFSR_EN
    lfsr = mode;
`else
    lfsr = mode & 1'b0;
`endif
    s = data;
    if (lfsr && s == '0) s = W'(1);
    for (int k = 0; k < NS; k++) begin
      if (k < W || !lfsr) begin
        exp_s[k] = s[W-1-(k%W)];
      end else begin
        fb = 1'b0;
        for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ exp_s[k-1-i];
        exp_s[k] = fb;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.load_mode = 1'b0;
    bus.en = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic load(input logic [W-1:0] data, input logic mode);
    bus.load_valid = 1'b1;
    bus.load_data = data;
    bus.load_mode = mode;
    bus.en = 1'b0;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    #1;
    vectors++;
    if (bus.q !== 1'b0 || bus.q_valid !== 1'b0 || bus.frame_start !== 1'b0 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: q=%b q_valid=%b fs=%b ready=%b, want 0 0 0 1",
               bus.q, bus.q_valid, bus.frame_start, bus.load_ready);
    end
  endtask

  task automatic test_rotate();
    logic [W-1:0] pat;
    logic         e;
    logic         last_q;
    int           k;
    for (int p = 0; p < 5; p++) begin
      pat = (p == 0) ? SPEC_PAT : W'($urandom);
      do_reset(1);
      load(pat, 1'b0);
      build_stream(pat, 1'b0);
      vectors++;
      if (bus.q_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rot_load_edge p=%0d: q_valid=%b, want 0", p, bus.q_valid);
      end
      k = 0;
      last_q = bus.q;
      for (int c = 0; c < 40; c++) begin
        e = (p == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.en = e;
        tick();
        vectors++;
        if (e) begin
          if (bus.q_valid !== 1'b1 || bus.q !== exp_s[k] || bus.frame_start !== (k % W == 0)) begin
            miscompares++;
            $display("FAIL rot_bit p=%0d k=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=1 fs=%b",
                     p, k, bus.q, bus.q_valid, bus.frame_start, exp_s[k], (k % W == 0));
          end
          last_q = bus.q;
          k++;
        end else begin
          if (bus.q_valid !== 1'b0 || bus.frame_start !== 1'b0 || bus.q !== last_q) begin
            miscompares++;
            $display("FAIL rot_hold p=%0d k=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=0 fs=0",
                     p, k, bus.q, bus.q_valid, bus.frame_start, last_q);
          end
        end
      end
      bus.en = 1'b0;
    end
  endtask

  task automatic test_pause();
    int k;
    do_reset(1);
    load(SPEC_PAT, 1'b0);
    build_stream(SPEC_PAT, 1'b0);
    k = 0;
    for (int c = 0; c < 13; c++) begin
      bus.en = !(c >= 5 && c < 8);
      tick();
      vectors++;
      if (bus.en) begin
        if (bus.q_valid !== 1'b1 || bus.q !== exp_s[k] || bus.frame_start !== (k == 0)) begin
          miscompares++;
          $display("FAIL pause_bit k=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=1 fs=%b",
                   k, bus.q, bus.q_valid, bus.frame_start, exp_s[k], (k == 0));
        end
        k++;
      end else begin
        if (bus.q_valid !== 1'b0 || bus.frame_start !== 1'b0 || bus.q !== exp_s[4]) begin
          miscompares++;
          $display("FAIL pause_hold c=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=0 fs=0",
                   c, bus.q, bus.q_valid, bus.frame_start, exp_s[4]);
        end
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         want;
    for (int it = 0; it < 2; it++) begin
      a = (it == 0) ? 10'h000 : W'($urandom);
      b = (it == 0) ? 10'h3FF : W'($urandom);
      do_reset(1);
      load(a, 1'b0);
      bus.load_valid = 1'b1;
      bus.load_data = b;
      bus.load_mode = 1'b0;
      bus.en = 1'b1;
      for (int k = 0; k < 30; k++) begin
        #1;
        vectors++;
        if (bus.load_ready !== (k % W == W - 1)) begin
          miscompares++;
          $display("FAIL b2b_ready it=%0d k=%0d: ready=%b, want %b",
                   it, k, bus.load_ready, (k % W == W - 1));
        end
        tick();
        if (k == W - 1) bus.load_valid = 1'b0;
        want = (k < W) ? a[W-1-k] : b[W-1-(k%W)];
        vectors++;
        if (bus.q_valid !== 1'b1 || bus.q !== want || bus.frame_start !== (k % W == 0)) begin
          miscompares++;
          $display("FAIL b2b_bit it=%0d k=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=1 fs=%b",
                   it, k, bus.q, bus.q_valid, bus.frame_start, want, (k % W == 0));
        end
      end
      bus.en = 1'b0;
    end
  endtask

  task automatic run_stream(input string name, input int n);
    bus.en = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      got_s[k] = bus.q;
      vectors++;
      if (bus.q_valid !== 1'b1 || bus.q !== exp_s[k] || bus.frame_start !== (k % W == 0)) begin
        miscompares++;
        $display("FAIL %s k=%0d: q=%b q_valid=%b fs=%b, want q=%b q_valid=1 fs=%b",
                 name, k, bus.q, bus.q_valid, bus.frame_start, exp_s[k], (k % W == 0));
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [W-1:0] pat;
    do_reset(1);
    load(10'h001, 1'b1);
    build_stream(10'h001, 1'b1);
    run_stream("lfsr_seed1", 1100);
`ifdef SEQ_GEN_LFSR_EN
    for (int n = 0; n < 60; n++) begin
      vectors++;
      if (got_s[n+1023] !== got_s[n]) begin
        miscompares++;
        $display("FAIL lfsr_period n=%0d: bit n+1023=%b, want %b", n, got_s[n+1023], got_s[n]);
      end
    end
`endif
    do_reset(1);
    load(10'h000, 1'b1);
    build_stream(10'h000, 1'b1);
    run_stream("lfsr_seed0", 120);
    pat = W'($urandom) | W'(1);
    do_reset(1);
    load(pat, 1'b1);
    build_stream(pat, 1'b1);
    run_stream("mode1_rand", 80);
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    load(SPEC_PAT, 1'b0);
    bus.en = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (bus.q !== 1'b0 || bus.q_valid !== 1'b0 || bus.frame_start !== 1'b0 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_state: q=%b q_valid=%b fs=%b ready=%b, want 0 0 0 1",
               bus.q, bus.q_valid, bus.frame_start, bus.load_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (bus.q !== 1'b0 || bus.q_valid !== 1'b0 || bus.frame_start !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_idle c=%0d: q=%b q_valid=%b fs=%b, want 0 0 0",
                 c, bus.q, bus.q_valid, bus.frame_start);
      end
    end
    load(SPEC_PAT, 1'b0);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    vectors++;
    if (bus.q !== SPEC_PAT[W-1] || bus.q_valid !== 1'b1 || bus.frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_reload: q=%b q_valid=%b fs=%b, want %b 1 1",
               bus.q, bus.q_valid, bus.frame_start, SPEC_PAT[W-1]);
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.load_mode = 1'b0;
    bus.en = 1'b0;
    test_reset();
    test_rotate();
    test_pause();
    test_back_to_back();
    test_lfsr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
